// File: rtl/board_io_cond.sv
// Board input conditioning: synchronised, debounced inputs with edge pulses, and a
// PLL-lock qualified core reset sequencer that releases only after a stable lock window.
module board_io_chan #(
    parameter int   DB_CYCLES = 50000,
    parameter int   EDGE_MODE = 0,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic raw_i,
    input  logic mask_i,
    output logic level_o,
    output logic pulse_o
);
    localparam int DW = $clog2(DB_CYCLES + 1);

    logic          s1, s;
    logic [DW-1:0] dc;
    logic          flip, hit;

    assign flip = (s != level_o) && (dc == DW'(DB_CYCLES - 1));

    always_comb begin
        hit = 1'b0;
        case (EDGE_MODE)
            0:       hit = flip & s;
            1:       hit = flip & ~s;
            default: hit = flip;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1      <= RST_VAL;
            s       <= RST_VAL;
            dc      <= '0;
            level_o <= RST_VAL;
            pulse_o <= 1'b0;
        end else begin
            s1 <= raw_i;
            s  <= s1;
            if (s == level_o) begin
                dc <= '0;
            end else if (flip) begin
                level_o <= s;
                dc      <= '0;
            end else begin
                dc <= dc + 1'b1;
            end
            // mask tracks the core reset value being registered this edge
            pulse_o <= hit & ~mask_i;
        end
    end
endmodule

module board_io_cond #(
    parameter int   NUM_IN    = 17,
    parameter int   DB_CYCLES = 50000,
    parameter int   EDGE_MODE = 0,
    parameter int   RST_HOLD  = 1024,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              pll_locked_i,
    input  logic [NUM_IN-1:0] raw_i,
    output logic              core_arst_o,
    output logic              run_o,
    output logic [NUM_IN-1:0] level_o,
    output logic [NUM_IN-1:0] pulse_o
);
    localparam int CW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {HOLD, COUNT, RUN} st_t;

    st_t           st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lk1, lk;
    logic          mask;

    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        case (st)
            HOLD: begin
                cnt_nxt = '0;
                if (lk) st_nxt = COUNT;
            end
            COUNT: begin
                if (!lk) begin
                    st_nxt  = HOLD;
                    cnt_nxt = '0;
                end else if (cnt == CW'(RST_HOLD - 1)) begin
                    st_nxt  = RUN;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lk) st_nxt = HOLD;
            end
            default: st_nxt = HOLD;
        endcase
    end

    assign mask = (st_nxt != RUN);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lk1         <= 1'b0;
            lk          <= 1'b0;
            st          <= HOLD;
            cnt         <= '0;
            core_arst_o <= 1'b1;
            run_o       <= 1'b0;
        end else begin
            lk1         <= pll_locked_i;
            lk          <= lk1;
            st          <= st_nxt;
            cnt         <= cnt_nxt;
            core_arst_o <= mask;
            run_o       <= ~mask;
        end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        board_io_chan #(
            .DB_CYCLES(DB_CYCLES),
            .EDGE_MODE(EDGE_MODE),
            .RST_VAL  (RST_VAL)
        ) u_ch (
            .clk_i  (clk_i),
            .arstn_i(arstn_i),
            .raw_i  (raw_i[i]),
            .mask_i (mask),
            .level_o(level_o[i]),
            .pulse_o(pulse_o[i])
        );
    end
endmodule

// File: tb/tb_board_io_cond.sv
// Randomised and directed bench for board_io_cond: three instances (one per edge mode)
// share stimulus; a reference model feeds a scoreboard queue checked by a monitor.
module tb_board_io_cond;
    localparam int N  = 3;
    localparam int DB = 4;
    localparam int RH = 8;

    logic         clk = 1'b0;
    logic         arstn = 1'b0;
    logic         pll = 1'b0;
    logic [N-1:0] raw = '0;

    logic         core_a [3];
    logic         run_a  [3];
    logic [N-1:0] lvl_a  [3];
    logic [N-1:0] pls_a  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        board_io_cond #(
            .NUM_IN(N), .DB_CYCLES(DB), .EDGE_MODE(g), .RST_HOLD(RH), .RST_VAL(1'b0)
        ) u_dut (
            .clk_i       (clk),
            .arstn_i     (arstn),
            .pll_locked_i(pll),
            .raw_i       (raw),
            .core_arst_o (core_a[g]),
            .run_o       (run_a[g]),
            .level_o     (lvl_a[g]),
            .pulse_o     (pls_a[g])
        );
    end

    typedef struct {
        logic                core;
        logic [N-1:0]        lvl;
        logic [2:0][N-1:0]   pls;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: history of sampled inputs plus streak counts of qualifying edges.
    logic         ph[2];
    logic [N-1:0] rh[2];
    int           lock_streak;
    int           diff_streak[N];
    logic [N-1:0] m_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model(output exp_t e);
        logic         lk;
        logic [N-1:0] s;
        logic [N-1:0] chg;
        e.pls = '0;
        chg   = '0;
        if (!arstn) begin
            ph[0] = 1'b0; ph[1] = 1'b0; rh[0] = '0; rh[1] = '0;
            lock_streak = 0;
            for (int i = 0; i < N; i++) diff_streak[i] = 0;
            m_lvl  = '0;
            e.core = 1'b1;
            e.lvl  = '0;
            return;
        end
        // values seen by the logic this edge were sampled two edges ago
        lk = ph[1]; ph[1] = ph[0]; ph[0] = pll;
        s  = rh[1]; rh[1] = rh[0]; rh[0] = raw;
        lock_streak = lk ? ((lock_streak > RH) ? RH + 1 : lock_streak + 1) : 0;
        e.core = (lock_streak <= RH);
        for (int i = 0; i < N; i++) begin
            if (s[i] != m_lvl[i]) begin
                diff_streak[i]++;
                if (diff_streak[i] == DB) begin
                    m_lvl[i] = s[i];
                    chg[i] = 1'b1;
                    diff_streak[i] = 0;
                end
            end else begin
                diff_streak[i] = 0;
            end
        end
        e.lvl = m_lvl;
        if (!e.core) begin
            e.pls[0] = chg & m_lvl;
            e.pls[1] = chg & ~m_lvl;
            e.pls[2] = chg;
        end
    endtask

    task automatic step(input logic a, input logic p, input logic [N-1:0] r);
        exp_t e;
        @(negedge clk);
        arstn = a; pll = p; raw = r;
        model(e);
        q.push_back(e);
    endtask

    task automatic hold(input int n, input logic a, input logic p, input logic [N-1:0] r);
        for (int k = 0; k < n; k++) step(a, p, r);
    endtask

    // Monitor: compares each instance after every edge for which an expectation exists.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int g = 0; g < 3; g++) begin
                    chk($sformatf("core_arst[m%0d]", g), 32'(core_a[g]), 32'(e.core));
                    chk($sformatf("run[m%0d]", g), 32'(run_a[g]), 32'(!e.core));
                    chk($sformatf("level[m%0d]", g), 32'(lvl_a[g]), 32'(e.lvl));
                    chk($sformatf("pulse[m%0d]", g), 32'(pls_a[g]), 32'(e.pls[g]));
                end
            end
        end
    end

    initial begin
        // reset then qualification with lock already high
        hold(3, 1'b0, 1'b1, 3'b000);
        hold(15, 1'b1, 1'b1, 3'b000);
        // clean press/release on ch0
        hold(10, 1'b1, 1'b1, 3'b001);
        hold(10, 1'b1, 1'b1, 3'b000);
        // ch1 glitch of 3 cycles rejected, 4 cycles accepted
        hold(3, 1'b1, 1'b1, 3'b010);
        hold(8, 1'b1, 1'b1, 3'b000);
        hold(4, 1'b1, 1'b1, 3'b010);
        hold(10, 1'b1, 1'b1, 3'b000);
        // ch2 press/release, then all channels together
        hold(10, 1'b1, 1'b1, 3'b100);
        hold(10, 1'b1, 1'b1, 3'b000);
        hold(10, 1'b1, 1'b1, 3'b111);
        hold(10, 1'b1, 1'b1, 3'b000);
        // one-cycle lock loss in RUN
        hold(1, 1'b1, 1'b0, 3'b000);
        hold(15, 1'b1, 1'b1, 3'b000);
        // lock glitch during qualification restarts it
        hold(1, 1'b1, 1'b0, 3'b000);
        hold(7, 1'b1, 1'b1, 3'b000);
        hold(1, 1'b1, 1'b0, 3'b000);
        hold(20, 1'b1, 1'b1, 3'b000);
        // press while core held in reset: level tracks, no pulse, none at release
        hold(1, 1'b1, 1'b0, 3'b000);
        hold(20, 1'b1, 1'b1, 3'b001);
        hold(10, 1'b1, 1'b1, 3'b000);
        // random phase
        begin
            logic         a, p;
            logic [N-1:0] r;
            a = 1'b1; p = 1'b1; r = '0;
            for (int k = 0; k < 2500; k++) begin
                a = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
                p = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
                step(a, p, r);
            end
        end
        hold(3, 1'b1, 1'b1, 3'b000);
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
